// File: rtl/wb_ibus_dbus_arbiter.sv
// Two-master (ibus/dbus) to single Wishbone-classic arbiter with locked grant,
// same-cycle ack routing, a stall watchdog and a sticky protocol checker.
module wb_ibus_dbus_arbiter #(
    parameter int unsigned TIMEOUT   = 8,
    parameter bit          DBUS_PRIO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout,
    output logic        o_proto_err,
    output logic [7:0]  o_wait_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t     state_q, state_d;
    logic       timeout_q, timeout_d;
    logic       proto_err_q, proto_err_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       granted_cyc;
    logic       ack_ok;

    // Ack is only honoured while the granted master still holds cyc, and never during reset.
    always_comb begin
        granted_cyc = ((state_q == GNT_I) && i_ibus_cyc) || ((state_q == GNT_D) && i_dbus_cyc);
        ack_ok      = i_wb_ack && granted_cyc && !reset;
        o_ibus_ack  = ack_ok && (state_q == GNT_I);
        o_dbus_ack  = ack_ok && (state_q == GNT_D);
        o_ibus_rdt  = i_wb_rdt;
        o_dbus_rdt  = i_wb_rdt;
        o_timeout   = timeout_q;
        o_proto_err = proto_err_q;
        o_wait_cnt  = wait_cnt_q;
    end

    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_adr = 32'h0;
        o_wb_dat = 32'h0;
        o_wb_sel = 4'h0;
        o_wb_we  = 1'b0;
        case (state_q)
            GNT_I: begin
                o_wb_cyc = i_ibus_cyc;
                o_wb_adr = i_ibus_adr;
                o_wb_sel = 4'hF;
            end
            GNT_D: begin
                o_wb_cyc = i_dbus_cyc;
                o_wb_adr = i_dbus_adr;
                o_wb_dat = i_dbus_dat;
                o_wb_sel = i_dbus_sel;
                o_wb_we  = i_dbus_we;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_wb_ack) proto_err_d = 1'b1;
                if (i_ibus_cyc && i_dbus_cyc) state_d = DBUS_PRIO ? GNT_D : GNT_I;
                else if (i_dbus_cyc)          state_d = GNT_D;
                else if (i_ibus_cyc)          state_d = GNT_I;
                if (state_d != IDLE) wait_cnt_d = 8'h0;
            end
            GNT_I, GNT_D: begin
                // A granted master dropping cyc early is an abort; any ack then is stray too.
                if (!granted_cyc) begin
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (i_wb_ack) begin
                    state_d = IDLE;
                end
                if (!(i_wb_ack && granted_cyc)) begin
                    wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
                    if (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_W) timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            wait_cnt_q  <= 8'h0;
        end else begin
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_ibus_dbus_arbiter.sv
// Directed bench for wb_ibus_dbus_arbiter; a second instance with DBUS_PRIO=0
// shares the stimulus to check the opposite priority on simultaneous requests.
module tb_wb_ibus_dbus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ibusAdr, dbusAdr, dbusDat, wbRdt;
    logic        ibusCyc, dbusCyc, dbusWe, wbAck;
    logic [3:0]  dbusSel;

    logic [31:0] ibusRdt, dbusRdt, wbAdr, wbDat;
    logic        ibusAck, dbusAck, wbWe, wbCyc, timeoutFlag, protoErr;
    logic [3:0]  wbSel;
    logic [7:0]  waitCnt;

    logic [31:0] ibusRdt0, dbusRdt0, wbAdr0, wbDat0;
    logic        ibusAck0, dbusAck0, wbWe0, wbCyc0, timeoutFlag0, protoErr0;
    logic [3:0]  wbSel0;
    logic [7:0]  waitCnt0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    wb_ibus_dbus_arbiter #(.TIMEOUT(8), .DBUS_PRIO(1'b1)) dut (
        .clock(clock), .reset(reset),
        .i_ibus_adr(ibusAdr), .i_ibus_cyc(ibusCyc), .o_ibus_rdt(ibusRdt), .o_ibus_ack(ibusAck),
        .i_dbus_adr(dbusAdr), .i_dbus_dat(dbusDat), .i_dbus_sel(dbusSel), .i_dbus_we(dbusWe),
        .i_dbus_cyc(dbusCyc), .o_dbus_rdt(dbusRdt), .o_dbus_ack(dbusAck),
        .o_wb_adr(wbAdr), .o_wb_dat(wbDat), .o_wb_sel(wbSel), .o_wb_we(wbWe), .o_wb_cyc(wbCyc),
        .i_wb_rdt(wbRdt), .i_wb_ack(wbAck),
        .o_timeout(timeoutFlag), .o_proto_err(protoErr), .o_wait_cnt(waitCnt)
    );

    wb_ibus_dbus_arbiter #(.TIMEOUT(8), .DBUS_PRIO(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .i_ibus_adr(ibusAdr), .i_ibus_cyc(ibusCyc), .o_ibus_rdt(ibusRdt0), .o_ibus_ack(ibusAck0),
        .i_dbus_adr(dbusAdr), .i_dbus_dat(dbusDat), .i_dbus_sel(dbusSel), .i_dbus_we(dbusWe),
        .i_dbus_cyc(dbusCyc), .o_dbus_rdt(dbusRdt0), .o_dbus_ack(dbusAck0),
        .o_wb_adr(wbAdr0), .o_wb_dat(wbDat0), .o_wb_sel(wbSel0), .o_wb_we(wbWe0), .o_wb_cyc(wbCyc0),
        .i_wb_rdt(wbRdt), .i_wb_ack(wbAck),
        .o_timeout(timeoutFlag0), .o_proto_err(protoErr0), .o_wait_cnt(waitCnt0)
    );

    // Advance to just after the next rising edge, where new inputs are driven.
    task automatic applyStimulus;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        ibusAdr = '0; ibusCyc = 1'b0;
        dbusAdr = '0; dbusDat = '0; dbusSel = '0; dbusWe = 1'b0; dbusCyc = 1'b0;
        wbRdt = '0; wbAck = 1'b0;
        applyStimulus;
        applyStimulus;
        reset = 1'b0;
        #1;
        checkOutput("rst_cyc", 32'(wbCyc), 32'd0);
        checkOutput("rst_adr", wbAdr, 32'h0);
        checkOutput("rst_timeout", 32'(timeoutFlag), 32'd0);
        checkOutput("rst_proto", 32'(protoErr), 32'd0);
        checkOutput("rst_wait", 32'(waitCnt), 32'd0);

        // Single fetch
        $display("[TB] single fetch");
        applyStimulus;
        ibusCyc = 1'b1; ibusAdr = 32'h100;
        #1;
        checkOutput("fetch_no_comb_cyc", 32'(wbCyc), 32'd0);
        applyStimulus;
        checkOutput("fetch_cyc", 32'(wbCyc), 32'd1);
        checkOutput("fetch_adr", wbAdr, 32'h100);
        checkOutput("fetch_sel", 32'(wbSel), 32'hF);
        checkOutput("fetch_we", 32'(wbWe), 32'd0);
        checkOutput("fetch_early_ack", 32'(ibusAck), 32'd0);
        applyStimulus;
        wbAck = 1'b1; wbRdt = 32'h13;
        #1;
        checkOutput("fetch_ack", 32'(ibusAck), 32'd1);
        checkOutput("fetch_rdt", ibusRdt, 32'h13);
        checkOutput("fetch_dack", 32'(dbusAck), 32'd0);
        applyStimulus;
        ibusCyc = 1'b0; wbAck = 1'b0;
        #1;
        checkOutput("fetch_idle", 32'(wbCyc), 32'd0);
        checkOutput("fetch_wait", 32'(waitCnt), 32'd1);

        // Simultaneous requests
        $display("[TB] simultaneous requests");
        applyStimulus;
        ibusCyc = 1'b1; ibusAdr = 32'h104;
        dbusCyc = 1'b1; dbusAdr = 32'h200; dbusWe = 1'b1; dbusSel = 4'h3; dbusDat = 32'hBEEF;
        applyStimulus;
        wbAck = 1'b1; wbRdt = 32'h55;
        #1;
        checkOutput("prio1_cyc", 32'(wbCyc), 32'd1);
        checkOutput("prio1_adr", wbAdr, 32'h200);
        checkOutput("prio1_we", 32'(wbWe), 32'd1);
        checkOutput("prio1_sel", 32'(wbSel), 32'h3);
        checkOutput("prio1_dat", wbDat, 32'hBEEF);
        checkOutput("prio1_dack", 32'(dbusAck), 32'd1);
        checkOutput("prio1_iack", 32'(ibusAck), 32'd0);
        checkOutput("prio0_adr", wbAdr0, 32'h104);
        checkOutput("prio0_we", 32'(wbWe0), 32'd0);
        checkOutput("prio0_iack", 32'(ibusAck0), 32'd1);
        checkOutput("prio0_dack", 32'(dbusAck0), 32'd0);
        applyStimulus;
        dbusCyc = 1'b0; dbusWe = 1'b0; wbAck = 1'b0;
        #1;
        checkOutput("prio1_gap", 32'(wbCyc), 32'd0);
        applyStimulus;
        checkOutput("prio1_second_cyc", 32'(wbCyc), 32'd1);
        checkOutput("prio1_second_adr", wbAdr, 32'h104);
        checkOutput("prio1_second_sel", 32'(wbSel), 32'hF);
        checkOutput("prio1_second_dat", wbDat, 32'h0);
        wbAck = 1'b1; wbRdt = 32'h77;
        #1;
        checkOutput("prio1_second_iack", 32'(ibusAck), 32'd1);
        checkOutput("prio1_proto", 32'(protoErr), 32'd0);
        applyStimulus;
        ibusCyc = 1'b0; wbAck = 1'b0;

        // Watchdog: request at R, grant R+1, timeout at R+9, ack at R+11
        $display("[TB] watchdog");
        applyStimulus;
        dbusCyc = 1'b1; dbusAdr = 32'h300; dbusSel = 4'hF;
        applyStimulus;
        checkOutput("wd_grant_cnt", 32'(waitCnt), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus;
        checkOutput("wd_cnt7", 32'(waitCnt), 32'd7);
        checkOutput("wd_not_yet", 32'(timeoutFlag), 32'd0);
        applyStimulus;
        checkOutput("wd_cnt8", 32'(waitCnt), 32'd8);
        checkOutput("wd_timeout", 32'(timeoutFlag), 32'd1);
        checkOutput("wd_still_cyc", 32'(wbCyc), 32'd1);
        applyStimulus;
        applyStimulus;
        wbAck = 1'b1; wbRdt = 32'hAA;
        #1;
        checkOutput("wd_late_ack", 32'(dbusAck), 32'd1);
        checkOutput("wd_late_rdt", dbusRdt, 32'hAA);
        applyStimulus;
        dbusCyc = 1'b0; wbAck = 1'b0;
        #1;
        checkOutput("wd_idle", 32'(wbCyc), 32'd0);
        checkOutput("wd_sticky", 32'(timeoutFlag), 32'd1);
        checkOutput("wd_cnt_final", 32'(waitCnt), 32'd10);

        // Stray ack while idle
        $display("[TB] stray ack");
        applyStimulus;
        wbAck = 1'b1;
        #1;
        checkOutput("stray_iack", 32'(ibusAck), 32'd0);
        checkOutput("stray_dack", 32'(dbusAck), 32'd0);
        checkOutput("stray_proto_before", 32'(protoErr), 32'd0);
        applyStimulus;
        wbAck = 1'b0;
        #1;
        checkOutput("stray_proto", 32'(protoErr), 32'd1);
        checkOutput("stray_cyc", 32'(wbCyc), 32'd0);
        checkOutput("stray_cnt_hold", 32'(waitCnt), 32'd10);

        reset = 1'b1;
        applyStimulus;
        reset = 1'b0;
        #1;
        checkOutput("clr_timeout", 32'(timeoutFlag), 32'd0);
        checkOutput("clr_proto", 32'(protoErr), 32'd0);
        checkOutput("clr_cnt", 32'(waitCnt), 32'd0);

        // Master abort then a normal dbus transaction
        $display("[TB] master abort");
        applyStimulus;
        ibusCyc = 1'b1; ibusAdr = 32'h400;
        applyStimulus;
        checkOutput("abort_grant", 32'(wbCyc), 32'd1);
        applyStimulus;
        ibusCyc = 1'b0;
        #1;
        checkOutput("abort_cyc_drop", 32'(wbCyc), 32'd0);
        applyStimulus;
        dbusCyc = 1'b1; dbusAdr = 32'h500; dbusSel = 4'hF;
        #1;
        checkOutput("abort_proto", 32'(protoErr), 32'd1);
        checkOutput("abort_idle_cyc", 32'(wbCyc), 32'd0);
        checkOutput("abort_idle_adr", wbAdr, 32'h0);
        applyStimulus;
        checkOutput("after_abort_cyc", 32'(wbCyc), 32'd1);
        checkOutput("after_abort_adr", wbAdr, 32'h500);
        wbAck = 1'b1;
        #1;
        checkOutput("after_abort_dack", 32'(dbusAck), 32'd1);
        applyStimulus;
        dbusCyc = 1'b0; wbAck = 1'b0;

        // Reset during a dbus grant with an ack pending
        $display("[TB] reset mid-grant");
        applyStimulus;
        dbusCyc = 1'b1; dbusAdr = 32'h600;
        applyStimulus;
        checkOutput("rstgnt_cyc", 32'(wbCyc), 32'd1);
        reset = 1'b1; wbAck = 1'b1;
        #1;
        checkOutput("rstgnt_ack_blocked", 32'(dbusAck), 32'd0);
        applyStimulus;
        reset = 1'b0; wbAck = 1'b0; dbusCyc = 1'b0;
        #1;
        checkOutput("rstgnt_cyc_after", 32'(wbCyc), 32'd0);
        checkOutput("rstgnt_adr_after", wbAdr, 32'h0);
        checkOutput("rstgnt_proto", 32'(protoErr), 32'd0);
        checkOutput("rstgnt_timeout", 32'(timeoutFlag), 32'd0);
        checkOutput("rstgnt_cnt", 32'(waitCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_ibus_dbus_arbiter.md
Name: wb_ibus_dbus_arbiter

Overview:
- Sits directly downstream of the core's instruction bus (ibus) and data bus (dbus).
- Merges them into one Wishbone-classic master port for a single memory or formal responder.
- Grant is registered and locked until the responder acks; read data and ack route back to the granted master only.
- Carries a stall watchdog and protocol checker. Formal benches use their sticky flags as bounded-latency and protocol properties.

Parameters:
- TIMEOUT, 8: granted cycles without ack before o_timeout sets; legal range 2..255.
- DBUS_PRIO, 1: 1 = dbus wins simultaneous requests in IDLE; 0 = ibus wins.

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- i_ibus_adr  in  32  instruction fetch address
- i_ibus_cyc  in  1  instruction request
- o_ibus_rdt  out  32  fetch data
- o_ibus_ack  out  1  fetch ack
- i_dbus_adr  in  32  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request
- o_dbus_rdt  out  32  load data
- o_dbus_ack  out  1  data ack
- o_wb_adr  out  32  merged address
- o_wb_dat  out  32  merged write data
- o_wb_sel  out  4  merged byte enables
- o_wb_we  out  1  merged write enable
- o_wb_cyc  out  1  merged request
- i_wb_rdt  in  32  responder read data
- i_wb_ack  in  1  responder ack
- o_timeout  out  1  sticky: watchdog expired
- o_proto_err  out  1  sticky: protocol violation seen
- o_wait_cnt  out  8  cycles spent in current or last grant, saturating

Behaviour:
- States: IDLE, GNT_I, GNT_D (registered).
- Reset (sync, active-high, highest priority): state=IDLE, o_timeout=0, o_proto_err=0, o_wait_cnt=0. All o_wb_* = 0; o_ibus_ack=o_dbus_ack=0.
- IDLE transitions:
  - Only one cyc high: go to the matching GNT state next cycle.
  - Both high: go to GNT_D if DBUS_PRIO=1, else GNT_I.
  - Neither high: stay IDLE.
- Request latency: cyc high at cycle N in IDLE gives o_wb_cyc=1 at N+1. No combinational path from i_*_cyc to o_wb_cyc.
- Outputs in IDLE: o_wb_cyc=0; adr/dat/sel/we driven 0.
- Outputs in GNT_I: o_wb_cyc=i_ibus_cyc, o_wb_adr=i_ibus_adr, o_wb_we=0, o_wb_sel=4'hF, o_wb_dat=0.
- Outputs in GNT_D: o_wb_cyc=i_dbus_cyc; adr/dat/sel/we follow the dbus inputs.
- Ack routing (combinational, same cycle):
  - o_ibus_ack = i_wb_ack & (state==GNT_I) & i_ibus_cyc; o_dbus_ack likewise for GNT_D.
  - Ungranted master ack is always 0.
  - o_ibus_rdt = o_dbus_rdt = i_wb_rdt (data only valid with its ack).
- Completion:
  - Ack in GNT state at cycle M: state=IDLE at M+1. Minimum one IDLE cycle between transactions.
  - A master still holding cyc at M+1 is treated as a new request and is arbitrated normally.
- Master abort: granted master drops cyc before ack → o_wb_cyc falls the same cycle, state=IDLE next cycle, o_proto_err sets.
- Stray ack: i_wb_ack=1 in IDLE, or while granted cyc=0 → ack suppressed, o_proto_err sets.
- Watchdog:
  - o_wait_cnt clears to 0 on entering GNT_I or GNT_D.
  - Increments each granted cycle with no ack; saturates at 255; holds its value in IDLE.
  - o_timeout sets when o_wait_cnt reaches TIMEOUT with no ack that cycle. The transaction is not aborted.
- Sticky flags clear only on reset.
- Reset mid-transaction: state forced to IDLE next edge; any ack arriving in the reset cycle is suppressed.

Test Plan:
- Single fetch: ibus_cyc=1 adr=0x100 at cycle 1, wb_ack with rdt=0x00000013 at cycle 3 → o_wb_cyc high at cycles 2–3, o_wb_adr=0x100, o_wb_sel=0xF, o_ibus_ack=1 with rdt=0x13 at cycle 3, state IDLE at cycle 4, o_wait_cnt=1.
- Simultaneous requests, DBUS_PRIO=1: both cyc rise at cycle 1, dbus we=1 sel=0x3 dat=0xBEEF.
  - dbus granted at cycle 2 with o_wb_we=1 sel=0x3; o_ibus_ack stays 0.
  - After dbus ack at cycle 2, ibus granted at cycle 4.
  - Repeat with DBUS_PRIO=0 → ibus granted first.
- Watchdog, TIMEOUT=8: grant with no ack for 8 cycles → o_timeout=1 at the cycle o_wait_cnt=8; ack at cycle 12 still completes normally; o_timeout stays 1 until reset.
- Stray ack: i_wb_ack=1 while IDLE → both master acks 0, o_proto_err=1 next cycle, no state change.
- Master abort: ibus granted, ibus_cyc drops before ack → o_wb_cyc=0 that cycle, IDLE next cycle, o_proto_err=1; a dbus request issued afterwards is granted normally.
- Reset mid-grant: reset high during GNT_D with pending ack → all outputs and flags 0 the cycle after reset; acks during reset are never forwarded.
